dcache_responder: RTL and testbench

Direct-mapped, write-through data cache that answers the pipeline's MEM-stage byte-lane load/store requests and forwards misses and all stores to a multi-cycle backing memory. It asserts `stall` while a backing transaction is outstanding. On load-miss completion it pulses `reg_write_enable_cache`, which the datapath ORs into its MEM→WB register-write enable. It also keeps hit and miss counters for performance runs.

---
 rtl/dcache_responder.sv | 169 ++++++++++++++++
 tb/tb_dcache_responder.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_responder.sv
// dcache_responder: direct-mapped, write-through, one-word-per-line data cache
// sitting between the MEM stage and a multi-cycle backing memory.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | accepting requests; load hits are answered in this cycle
// S_RD_WAIT | load miss outstanding, bk_rd held until bk_ready
// S_WR_WAIT | store outstanding (write-through), bk_wr held until bk_ready
// S_DONE    | one-cycle release of the pipeline; fill data shown after a read
module dcache_responder #(
    parameter int NUM_LINES = 64,
    parameter int XLEN      = 32
) (
    input  logic            clk,
    input  logic            rst_b,
    input  logic [XLEN-1:0] cpu_addr,
    input  logic [7:0]      cpu_wdata [0:3],
    input  logic            cpu_rd,
    input  logic            cpu_wr,
    output logic [7:0]      cpu_rdata [0:3],
    output logic            stall,
    output logic            reg_write_enable_cache,
    output logic [XLEN-1:0] bk_addr,
    output logic [XLEN-1:0] bk_wdata,
    output logic            bk_rd,
    output logic            bk_wr,
    input  logic            bk_ready,
    input  logic [XLEN-1:0] bk_rdata,
    output logic [31:0]     hit_count,
    output logic [31:0]     miss_count
);

    localparam int IDX  = $clog2(NUM_LINES);
    localparam int TAGW = XLEN - IDX - 2;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RD_WAIT = 2'd1,
        S_WR_WAIT = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t                state_q;
    logic [NUM_LINES-1:0]  valid_q;
    logic [TAGW-1:0]       tag_q  [NUM_LINES];
    logic [31:0]           data_q [NUM_LINES];
    logic [XLEN-1:0]       bk_addr_q;
    logic [XLEN-1:0]       bk_wdata_q;
    logic                  bk_rd_q;
    logic                  bk_wr_q;
    logic [31:0]           fill_q;
    logic                  rwe_q;
    logic [31:0]           hit_count_q;
    logic [31:0]           miss_count_q;

    logic [IDX-1:0]        cpu_idx;
    logic [TAGW-1:0]       cpu_tag;
    logic [IDX-1:0]        bk_idx;
    logic [TAGW-1:0]       bk_tag;
    logic [XLEN-1:0]       word_addr;
    logic [31:0]           wr_word;
    logic                  hit;
    logic                  idle_load;
    logic [31:0]           rdata_word;
    logic                  unused_addr_lsb;

    assign cpu_idx   = cpu_addr[IDX+1:2];
    assign cpu_tag   = cpu_addr[XLEN-1:IDX+2];
    assign bk_idx    = bk_addr_q[IDX+1:2];
    assign bk_tag    = bk_addr_q[XLEN-1:IDX+2];
    assign word_addr = {cpu_addr[XLEN-1:2], 2'b00};
    assign wr_word   = {cpu_wdata[3], cpu_wdata[2], cpu_wdata[1], cpu_wdata[0]};
    assign hit       = valid_q[cpu_idx] && (tag_q[cpu_idx] == cpu_tag);
    // Store has priority, so a load only counts when cpu_wr is low.
    assign idle_load = (state_q == S_IDLE) && cpu_rd && !cpu_wr;

    assign unused_addr_lsb = ^cpu_addr[1:0];

    // Control FSM; every backing-side output and the counters are registered here.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q      <= S_IDLE;
            valid_q      <= '0;
            bk_addr_q    <= '0;
            bk_wdata_q   <= '0;
            bk_rd_q      <= 1'b0;
            bk_wr_q      <= 1'b0;
            fill_q       <= '0;
            rwe_q        <= 1'b0;
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            rwe_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (cpu_wr) begin
                        bk_addr_q  <= word_addr;
                        bk_wdata_q <= XLEN'(wr_word);
                        bk_wr_q    <= 1'b1;
                        state_q    <= S_WR_WAIT;
                    end else if (cpu_rd) begin
                        if (hit) begin
                            hit_count_q <= hit_count_q + 32'd1;
                        end else begin
                            miss_count_q <= miss_count_q + 32'd1;
                            bk_addr_q    <= word_addr;
                            bk_rd_q      <= 1'b1;
                            state_q      <= S_RD_WAIT;
                        end
                    end
                end
                S_RD_WAIT: begin
                    if (bk_ready) begin
                        valid_q[bk_idx] <= 1'b1;
                        fill_q          <= bk_rdata[31:0];
                        bk_rd_q         <= 1'b0;
                        rwe_q           <= 1'b1;
                        state_q         <= S_DONE;
                    end
                end
                S_WR_WAIT: begin
                    if (bk_ready) begin
                        bk_wr_q <= 1'b0;
                        state_q <= S_DONE;
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Line tag/data storage; validity lives in the reset domain above, so no reset needed.
    always_ff @(posedge clk) begin
        if ((state_q == S_IDLE) && cpu_wr && hit) begin
            data_q[cpu_idx] <= wr_word;
        end else if ((state_q == S_RD_WAIT) && bk_ready) begin
            tag_q[bk_idx]  <= bk_tag;
            data_q[bk_idx] <= bk_rdata[31:0];
        end
    end

    // Load data mux: hit data in IDLE, fill data in DONE after a read, zero otherwise.
    always_comb begin
        rdata_word = '0;
        if (idle_load && hit) begin
            rdata_word = data_q[cpu_idx];
        end else if ((state_q == S_DONE) && rwe_q) begin
            rdata_word = fill_q;
        end
    end

    assign cpu_rdata[0] = rdata_word[7:0];
    assign cpu_rdata[1] = rdata_word[15:8];
    assign cpu_rdata[2] = rdata_word[23:16];
    assign cpu_rdata[3] = rdata_word[31:24];

    assign stall = ((state_q == S_IDLE) && (cpu_wr || (cpu_rd && !hit)))
                 || (state_q == S_RD_WAIT) || (state_q == S_WR_WAIT);

    assign reg_write_enable_cache = rwe_q;
    assign bk_addr                = bk_addr_q;
    assign bk_wdata               = bk_wdata_q;
    assign bk_rd                  = bk_rd_q;
    assign bk_wr                  = bk_wr_q;
    assign hit_count              = hit_count_q;
    assign miss_count             = miss_count_q;

endmodule

// File: tb/tb_dcache_responder.sv
// Randomized bench for dcache_responder against a word-level cache/memory model.
module tb_dcache_responder;

    localparam int NL = 64;

    logic        clk = 1'b0;
    logic        rst_b = 1'b0;
    logic [31:0] cpu_addr = '0;
    logic [7:0]  cpu_wdata [0:3];
    logic        cpu_rd = 1'b0;
    logic        cpu_wr = 1'b0;
    logic [7:0]  cpu_rdata [0:3];
    logic        stall;
    logic        reg_write_enable_cache;
    logic [31:0] bk_addr;
    logic [31:0] bk_wdata;
    logic        bk_rd;
    logic        bk_wr;
    logic        bk_ready = 1'b0;
    logic [31:0] bk_rdata = '0;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    dcache_responder #(.NUM_LINES(NL), .XLEN(32)) dut (
        .clk                    (clk),
        .rst_b                  (rst_b),
        .cpu_addr               (cpu_addr),
        .cpu_wdata              (cpu_wdata),
        .cpu_rd                 (cpu_rd),
        .cpu_wr                 (cpu_wr),
        .cpu_rdata              (cpu_rdata),
        .stall                  (stall),
        .reg_write_enable_cache (reg_write_enable_cache),
        .bk_addr                (bk_addr),
        .bk_wdata               (bk_wdata),
        .bk_rd                  (bk_rd),
        .bk_wr                  (bk_wr),
        .bk_ready               (bk_ready),
        .bk_rdata               (bk_rdata),
        .hit_count              (hit_count),
        .miss_count             (miss_count)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: which word address each line currently holds, plus backing memory.
    bit          m_valid [NL];
    logic [31:0] m_waddr [NL];
    logic [31:0] m_data  [NL];
    logic [31:0] bmem    [int unsigned];
    int unsigned m_hit  = 0;
    int unsigned m_miss = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rword();
        return {cpu_rdata[3], cpu_rdata[2], cpu_rdata[1], cpu_rdata[0]};
    endfunction

    function automatic logic [31:0] bmem_get(input logic [31:0] wa);
        if (!bmem.exists(wa)) bmem[wa] = $urandom;
        return bmem[wa];
    endfunction

    function automatic bit model_hit(input logic [31:0] addr);
        int ix;
        ix = (addr / 4) % NL;
        return m_valid[ix] && (m_waddr[ix] == (addr & 32'hFFFF_FFFC));
    endfunction

    task automatic idle_cycle();
        @(posedge clk); #1;
        cpu_rd   = 1'b0;
        cpu_wr   = 1'b0;
        bk_ready = 1'($urandom_range(0, 1));
        bk_rdata = $urandom;
        @(negedge clk);
        chk("idle_stall", stall, 0);
        chk("idle_bk", {bk_rd, bk_wr}, 0);
        chk("idle_rdata", rword(), 0);
        chk("idle_rwe", reg_write_enable_cache, 0);
    endtask

    // One load or store, held level through DONE; lat = cycle of bk_rd/bk_wr high that sees bk_ready.
    task automatic do_op(input bit wr, input logic [31:0] addr, input logic [31:0] wd, input int lat);
        logic [31:0] wa;
        logic [31:0] exp_rd;
        int          ix;
        bit          h;
        int          stall_cyc;
        wa = addr & 32'hFFFF_FFFC;
        ix = (addr / 4) % NL;
        h  = model_hit(addr);
        exp_rd = '0;
        @(posedge clk); #1;
        cpu_addr = addr;
        cpu_wr   = wr;
        cpu_rd   = wr ? 1'($urandom_range(0, 1)) : 1'b1;
        for (int i = 0; i < 4; i++) cpu_wdata[i] = wd[8*i +: 8];
        bk_ready = 1'($urandom_range(0, 1));
        bk_rdata = $urandom;
        @(negedge clk);
        chk("hit_count", hit_count, m_hit);
        chk("miss_count", miss_count, m_miss);
        if (!wr && h) begin
            chk("hit_stall", stall, 0);
            chk("hit_data", rword(), m_data[ix]);
            chk("hit_bk", {bk_rd, bk_wr}, 0);
            chk("hit_rwe", reg_write_enable_cache, 0);
            m_hit++;
            return;
        end
        chk("req_stall", stall, 1);
        chk("req_bk", {bk_rd, bk_wr}, 0);
        stall_cyc = 1;
        if (wr) begin
            if (h) m_data[ix] = wd;
            bmem[wa] = wd;
        end else begin
            m_miss++;
            exp_rd = bmem_get(wa);
        end
        for (int k = 1; k <= lat; k++) begin
            @(posedge clk); #1;
            bk_ready = (k == lat);
            bk_rdata = (k == lat) ? exp_rd : $urandom;
            @(negedge clk);
            chk(wr ? "bk_wr_held" : "bk_rd_held", {bk_rd, bk_wr}, wr ? 2'b01 : 2'b10);
            chk("bk_addr", bk_addr, wa);
            if (wr) chk("bk_wdata", bk_wdata, wd);
            chk("wait_rdata", rword(), 0);
            if (stall) stall_cyc++;
        end
        chk("stall_cycles", stall_cyc, lat + 1);
        @(posedge clk); #1;
        bk_ready = 1'($urandom_range(0, 1));
        bk_rdata = $urandom;
        @(negedge clk);
        chk("done_stall", stall, 0);
        chk("done_bk", {bk_rd, bk_wr}, 0);
        chk("done_rwe", reg_write_enable_cache, wr ? 0 : 1);
        chk("done_rdata", rword(), wr ? 32'h0 : exp_rd);
        if (!wr) begin
            m_valid[ix] = 1'b1;
            m_waddr[ix] = wa;
            m_data[ix]  = exp_rd;
        end
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] tg;
        logic [31:0] ix;
        tg = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(4, 255)) : 32'($urandom_range(0, 3));
        ix = 32'($urandom_range(0, 7));
        return (tg << 8) | (ix << 2) | 32'($urandom_range(0, 3));
    endfunction

    initial begin
        logic [31:0] ra;
        for (int i = 0; i < 4; i++) cpu_wdata[i] = '0;
        for (int i = 0; i < NL; i++) begin
            m_valid[i] = 1'b0;
            m_waddr[i] = '0;
            m_data[i]  = '0;
        end

        // Reset state
        @(negedge clk);
        chk("rst_stall", stall, 0);
        chk("rst_bk", {bk_rd, bk_wr}, 0);
        chk("rst_bk_addr", bk_addr, 0);
        chk("rst_bk_wdata", bk_wdata, 0);
        chk("rst_rwe", reg_write_enable_cache, 0);
        chk("rst_rdata", rword(), 0);
        chk("rst_hits", hit_count, 0);
        chk("rst_misses", miss_count, 0);
        @(posedge clk); #1;
        rst_b = 1'b1;

        // Directed scenarios
        bmem[32'h100] = 32'hDEADBEEF;
        do_op(0, 32'h100, 0, 3);
        do_op(0, 32'h101, 0, 1);
        do_op(1, 32'h100, 32'h12345678, 2);
        do_op(0, 32'h100, 0, 1);
        do_op(1, 32'h200, 32'hCAFEF00D, 1);
        do_op(0, 32'h200, 0, 1);
        do_op(0, 32'h100, 0, 2);
        do_op(0, 32'h200, 0, 1);
        idle_cycle();
        idle_cycle();

        // Random mix
        for (int n = 0; n < 250; n++) begin
            ra = rand_addr();
            case ($urandom_range(0, 9))
                0:       idle_cycle();
                1, 2, 3: do_op(1, ra, $urandom, $urandom_range(1, 4));
                default: do_op(0, ra, 0, $urandom_range(1, 4));
            endcase
        end
        idle_cycle();

        // Reset during RD_WAIT
        ra = 32'hFFFF_0F00;
        @(posedge clk); #1;
        cpu_addr = ra; cpu_rd = 1'b1; cpu_wr = 1'b0; bk_ready = 1'b0;
        @(negedge clk);
        chk("rr_req_stall", stall, 1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rr_bk_rd", bk_rd, 1);
        @(posedge clk); #1;
        cpu_rd = 1'b0;
        #2 rst_b = 1'b0;
        #1;
        chk("rr_bk_rd_async", bk_rd, 0);
        chk("rr_stall", stall, 0);
        for (int i = 0; i < NL; i++) m_valid[i] = 1'b0;
        m_hit  = 0;
        m_miss = 0;
        @(posedge clk); #1;
        bk_ready = 1'b1;
        bk_rdata = $urandom;
        rst_b    = 1'b1;
        @(negedge clk);
        chk("rr_late_ready_bk", {bk_rd, bk_wr}, 0);
        chk("rr_late_ready_stall", stall, 0);
        chk("rr_hits", hit_count, 0);
        chk("rr_misses", miss_count, 0);
        do_op(0, ra, 0, 2);
        do_op(0, ra, 0, 1);
        idle_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
